// File: rtl/cc_alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU selection codes, sequencer
// state encoding and condition-code bit positions.
package cc_alu_pkg;

    localparam logic [3:0] ALU_BUSA  = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ADDCC = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_ADD   = 4'b1000;
    localparam logic [3:0] ALU_SUB   = 4'b1001;
    localparam logic [3:0] ALU_INC   = 4'b1010;
    localparam logic [3:0] ALU_DEC   = 4'b1011;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_EXEC = 2'd1,
        STATE_MUL  = 2'd2,
        STATE_RESP = 2'd3
    } seqState_t;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

endpackage

// File: rtl/cc_icc_register.sv
// Architectural condition-code register {N,Z,V,C}; loads either the inverted
// active-low ALU flags or the locally computed multiply N/Z.
module cc_icc_register
    import cc_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       selMul,
    input  logic       aluNegativeLow,
    input  logic       aluZeroLow,
    input  logic       aluOverflowLow,
    input  logic       aluCarryLow,
    input  logic       mulNegative,
    input  logic       mulZero,
    output logic [3:0] icc
);

    logic [3:0] iccNext;

    // Multiply results never report overflow or carry, so V and C clear.
    always_comb begin
        iccNext = '0;
        if (selMul) begin
            iccNext[ICC_N] = mulNegative;
            iccNext[ICC_Z] = mulZero;
        end else begin
            iccNext[ICC_N] = ~aluNegativeLow;
            iccNext[ICC_Z] = ~aluZeroLow;
            iccNext[ICC_V] = ~aluOverflowLow;
            iccNext[ICC_C] = ~aluCarryLow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icc <= '0;
        end else if (load) begin
            icc <= iccNext;
        end
    end

endmodule

// File: rtl/cc_alu_sequencer.sv
// Command-level owner of the shared ALU: runs single ALU ops, a shift-and-add
// multiply through the ALU ADD path, and returns results over valid/ready.
module cc_alu_sequencer
    import cc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_MULCNT        = 6
) (
    input  logic                               CC_ALUSEQ_CLOCK_50,
    input  logic                               CC_ALUSEQ_RESET_InHigh,
    input  logic                               CC_ALUSEQ_cmdValid_In,
    output logic                               CC_ALUSEQ_cmdReady_Out,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_cmdOp_InBus,
    input  logic                               CC_ALUSEQ_cmdMul_In,
    input  logic                               CC_ALUSEQ_cmdSetCC_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_cmdDataA_InBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_cmdDataB_InBus,
    output logic                               CC_ALUSEQ_rspValid_Out,
    input  logic                               CC_ALUSEQ_rspReady_In,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_rspData_OutBus,
    output logic [3:0]                         CC_ALUSEQ_icc_OutBus,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_aluSelection_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataA_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataB_OutBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluData_InBus,
    input  logic                               CC_ALUSEQ_aluOverflow_InLow,
    input  logic                               CC_ALUSEQ_aluCarry_InLow,
    input  logic                               CC_ALUSEQ_aluNegative_InLow,
    input  logic                               CC_ALUSEQ_aluZero_InLow
);

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_NOP = DATAWIDTH_ALU_SELECTION'(ALU_NOP);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADD = DATAWIDTH_ALU_SELECTION'(ALU_ADD);
    localparam logic [DATAWIDTH_MULCNT-1:0]        CNT_LAST = DATAWIDTH_MULCNT'(DATAWIDTH_BUS - 1);

    seqState_t state;
    seqState_t stateNext;

    logic [DATAWIDTH_ALU_SELECTION-1:0] opReg;
    logic                               setCCReg;
    logic [DATAWIDTH_BUS-1:0]           aReg;
    logic [DATAWIDTH_BUS-1:0]           bReg;
    logic [DATAWIDTH_BUS-1:0]           acc;
    logic [DATAWIDTH_BUS-1:0]           mcand;
    logic [DATAWIDTH_BUS-1:0]           mplier;
    logic [DATAWIDTH_MULCNT-1:0]        cnt;
    logic [DATAWIDTH_BUS-1:0]           rspData;

    logic                     cmdAccept;
    logic                     rspDone;
    logic                     mulLast;
    logic [DATAWIDTH_BUS-1:0] accAfter;
    logic                     iccLoad;

    assign cmdAccept = CC_ALUSEQ_cmdValid_In && (state == STATE_IDLE);
    assign rspDone   = (state == STATE_RESP) && CC_ALUSEQ_rspReady_In;
    assign mulLast   = (cnt == CNT_LAST);
    // Accumulator value after the current iteration, used for both the
    // running update and the final result/flags on the last iteration.
    assign accAfter  = mplier[0] ? CC_ALUSEQ_aluData_InBus : acc;
    assign iccLoad   = setCCReg && ((state == STATE_EXEC) || ((state == STATE_MUL) && mulLast));

    always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
        if (CC_ALUSEQ_RESET_InHigh) begin
            state <= STATE_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            STATE_IDLE: if (cmdAccept) stateNext = CC_ALUSEQ_cmdMul_In ? STATE_MUL : STATE_EXEC;
            STATE_EXEC: stateNext = STATE_RESP;
            STATE_MUL:  if (mulLast) stateNext = STATE_RESP;
            STATE_RESP: if (rspDone) stateNext = STATE_IDLE;
            default:    stateNext = STATE_IDLE;
        endcase
    end

    always_comb begin
        CC_ALUSEQ_cmdReady_Out        = 1'b0;
        CC_ALUSEQ_rspValid_Out        = 1'b0;
        CC_ALUSEQ_aluSelection_OutBus = SEL_NOP;
        CC_ALUSEQ_aluDataA_OutBus     = '0;
        CC_ALUSEQ_aluDataB_OutBus     = '0;
        case (state)
            STATE_IDLE: CC_ALUSEQ_cmdReady_Out = 1'b1;
            STATE_EXEC: begin
                CC_ALUSEQ_aluSelection_OutBus = opReg;
                CC_ALUSEQ_aluDataA_OutBus     = aReg;
                CC_ALUSEQ_aluDataB_OutBus     = bReg;
            end
            STATE_MUL: begin
                CC_ALUSEQ_aluSelection_OutBus = SEL_ADD;
                CC_ALUSEQ_aluDataA_OutBus     = acc;
                CC_ALUSEQ_aluDataB_OutBus     = mcand;
            end
            STATE_RESP: CC_ALUSEQ_rspValid_Out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
        if (CC_ALUSEQ_RESET_InHigh) begin
            opReg    <= '0;
            setCCReg <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            rspData  <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (cmdAccept) begin
                        opReg    <= CC_ALUSEQ_cmdOp_InBus;
                        setCCReg <= CC_ALUSEQ_cmdSetCC_In;
                        aReg     <= CC_ALUSEQ_cmdDataA_InBus;
                        bReg     <= CC_ALUSEQ_cmdDataB_InBus;
                        acc      <= '0;
                        mcand    <= CC_ALUSEQ_cmdDataA_InBus;
                        mplier   <= CC_ALUSEQ_cmdDataB_InBus;
                        cnt      <= '0;
                    end
                end
                STATE_EXEC: rspData <= CC_ALUSEQ_aluData_InBus;
                STATE_MUL: begin
                    acc    <= accAfter;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + DATAWIDTH_MULCNT'(1);
                    if (mulLast) begin
                        rspData <= accAfter;
                    end
                end
                default: ;
            endcase
        end
    end

    cc_icc_register iccRegister (
        .clk            (CC_ALUSEQ_CLOCK_50),
        .reset          (CC_ALUSEQ_RESET_InHigh),
        .load           (iccLoad),
        .selMul         (state == STATE_MUL),
        .aluNegativeLow (CC_ALUSEQ_aluNegative_InLow),
        .aluZeroLow     (CC_ALUSEQ_aluZero_InLow),
        .aluOverflowLow (CC_ALUSEQ_aluOverflow_InLow),
        .aluCarryLow    (CC_ALUSEQ_aluCarry_InLow),
        .mulNegative    (accAfter[DATAWIDTH_BUS-1]),
        .mulZero        (accAfter == '0),
        .icc            (CC_ALUSEQ_icc_OutBus)
    );

    assign CC_ALUSEQ_rspData_OutBus = rspData;

endmodule

// File: tb/tb_cc_alu_sequencer.sv
// Scoreboard bench for cc_alu_sequencer with a small behavioural ALU attached
// to its ALU buses.
module tb_cc_alu_sequencer;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_NOP = 4'b1111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [3:0]  cmdOp = 4'b0;
    logic        cmdMul = 1'b0;
    logic        cmdSetCC = 1'b0;
    logic [31:0] cmdDataA = '0;
    logic [31:0] cmdDataB = '0;
    logic        rspValid;
    logic        rspReady = 1'b1;
    logic [31:0] rspData;
    logic [3:0]  icc;
    logic [3:0]  aluSel;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [31:0] aluResult;
    logic        aluOverflowLow;
    logic        aluCarryLow;
    logic        aluNegativeLow;
    logic        aluZeroLow;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  icc;
        int          lat;
        int          acceptCycle;
    } expect_t;

    expect_t expq[$];
    int      checkCount = 0;
    int      passCount = 0;
    int      cycleCount = 0;
    int      lastAccept = 0;
    int      hCycle = 0;
    logic    prevValid = 1'b0;

    cc_alu_sequencer dut (
        .CC_ALUSEQ_CLOCK_50            (clock),
        .CC_ALUSEQ_RESET_InHigh        (reset),
        .CC_ALUSEQ_cmdValid_In         (cmdValid),
        .CC_ALUSEQ_cmdReady_Out        (cmdReady),
        .CC_ALUSEQ_cmdOp_InBus         (cmdOp),
        .CC_ALUSEQ_cmdMul_In           (cmdMul),
        .CC_ALUSEQ_cmdSetCC_In         (cmdSetCC),
        .CC_ALUSEQ_cmdDataA_InBus      (cmdDataA),
        .CC_ALUSEQ_cmdDataB_InBus      (cmdDataB),
        .CC_ALUSEQ_rspValid_Out        (rspValid),
        .CC_ALUSEQ_rspReady_In         (rspReady),
        .CC_ALUSEQ_rspData_OutBus      (rspData),
        .CC_ALUSEQ_icc_OutBus          (icc),
        .CC_ALUSEQ_aluSelection_OutBus (aluSel),
        .CC_ALUSEQ_aluDataA_OutBus     (aluA),
        .CC_ALUSEQ_aluDataB_OutBus     (aluB),
        .CC_ALUSEQ_aluData_InBus       (aluResult),
        .CC_ALUSEQ_aluOverflow_InLow   (aluOverflowLow),
        .CC_ALUSEQ_aluCarry_InLow      (aluCarryLow),
        .CC_ALUSEQ_aluNegative_InLow   (aluNegativeLow),
        .CC_ALUSEQ_aluZero_InLow       (aluZeroLow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Behavioural ALU with active-low flags.
    logic [32:0] wide;
    logic        aluV;
    always_comb begin
        wide      = '0;
        aluV      = 1'b0;
        aluResult = '0;
        case (aluSel)
            4'b0000: aluResult = aluA;
            4'b0001: aluResult = aluA | aluB;
            4'b0010: aluResult = aluA & aluB;
            4'b0100: aluResult = aluA ^ aluB;
            4'b0011, 4'b1000: begin
                wide      = {1'b0, aluA} + {1'b0, aluB};
                aluResult = wide[31:0];
                aluV      = (aluA[31] == aluB[31]) && (aluResult[31] != aluA[31]);
            end
            4'b1001: begin
                wide      = {1'b0, aluA} - {1'b0, aluB};
                aluResult = wide[31:0];
                aluV      = (aluA[31] != aluB[31]) && (aluResult[31] != aluA[31]);
            end
            4'b1010: aluResult = aluA + 32'd1;
            4'b1011: aluResult = aluA - 32'd1;
            default: aluResult = '0;
        endcase
        aluOverflowLow = ~aluV;
        aluCarryLow    = ~wide[32];
        aluNegativeLow = ~aluResult[31];
        aluZeroLow     = ~(aluResult == 32'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failOnly(input string name);
        checkCount++;
        $display("[TB] FAIL %s", name);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic applyStimulus(input logic [3:0] op, input logic mul, input logic setCC,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expData, input logic [3:0] expIcc, input int expLat);
        bit accepted;
        expect_t item;
        accepted = 1'b0;
        cmdOp    = op;
        cmdMul   = mul;
        cmdSetCC = setCC;
        cmdDataA = a;
        cmdDataB = b;
        cmdValid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clock);
            if (cmdReady) begin
                @(posedge clock);
                #1;
                accepted = 1'b1;
            end
        end
        cmdValid = 1'b0;
        if (accepted) begin
            lastAccept       = cycleCount;
            item.data        = expData;
            item.icc         = expIcc;
            item.lat         = expLat;
            item.acceptCycle = lastAccept;
            expq.push_back(item);
        end else begin
            failOnly("command accept timeout");
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100; i++) begin
            if (expq.size() == 0) break;
            @(posedge clock);
        end
        if (expq.size() != 0) begin
            failOnly("response timeout");
            expq.delete();
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare each response against the scoreboard head when it appears.
    always @(negedge clock) begin
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            if (rspValid && !prevValid) begin
                if (expq.size() == 0) begin
                    failOnly("unexpected response");
                end else begin
                    checkOutput("latency", 32'(cycleCount - expq[0].acceptCycle + 1), 32'(expq[0].lat));
                    checkOutput("rspData", rspData, expq[0].data);
                    checkOutput("icc", {28'd0, icc}, {28'd0, expq[0].icc});
                end
            end
            if (rspValid && rspReady && expq.size() != 0) begin
                void'(expq.pop_front());
            end
            prevValid = rspValid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset cmdReady", {31'd0, cmdReady}, 32'd1);
        checkOutput("reset rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset rspData", rspData, 32'd0);
        checkOutput("reset icc", {28'd0, icc}, 32'd0);
        checkOutput("reset aluSel", {28'd0, aluSel}, {28'd0, OP_NOP});

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("idle aluSel", {28'd0, aluSel}, {28'd0, OP_NOP});
            checkOutput("idle aluA", aluA, 32'd0);
            checkOutput("idle aluB", aluB, 32'd0);
            checkOutput("idle rspValid", {31'd0, rspValid}, 32'd0);
        end
        @(posedge clock);
        #1;

        applyStimulus(OP_ADD, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1010, 2);
        waitDrain();
        applyStimulus(OP_SUB, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 4'b1010, 2);
        waitDrain();

        rspReady = 1'b0;
        applyStimulus(OP_ADD, 1'b0, 1'b1, 32'd10, 32'd20, 32'd30, 4'b0000, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = rspValid;
        end
        if (!seen) failOnly("backpressure response timeout");
        @(posedge clock);
        #1;
        cmdOp    = OP_SUB;
        cmdMul   = 1'b0;
        cmdSetCC = 1'b0;
        cmdDataA = 32'd9;
        cmdDataB = 32'd4;
        cmdValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("hold rspData", rspData, 32'd30);
            checkOutput("hold icc", {28'd0, icc}, 32'd0);
            checkOutput("hold cmdReady", {31'd0, cmdReady}, 32'd0);
            checkOutput("hold rspValid", {31'd0, rspValid}, 32'd1);
        end
        @(posedge clock);
        #1;
        rspReady = 1'b1;
        @(negedge clock);
        checkOutput("handshake cmdReady", {31'd0, cmdReady}, 32'd0);
        @(posedge clock);
        #1;
        hCycle = cycleCount;
        applyStimulus(OP_SUB, 1'b0, 1'b0, 32'd9, 32'd4, 32'd5, 4'b0000, 2);
        checkOutput("accept after handshake", 32'(lastAccept), 32'(hCycle + 1));
        waitDrain();

        applyStimulus(OP_NOP, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 4'b0000, 33);
        waitDrain();
        applyStimulus(OP_NOP, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0100, 33);
        waitDrain();

        applyStimulus(OP_NOP, 1'b1, 1'b1, 32'd3, 32'd5, 32'd15, 4'b0000, 33);
        repeat (10) @(posedge clock);
        @(negedge clock);
        checkOutput("mul aluSel", {28'd0, aluSel}, {28'd0, OP_ADD});
        checkOutput("mul aluA acc", aluA, 32'd15);
        checkOutput("mul aluB mcand", aluB, 32'd3072);
        reset = 1'b1;
        expq.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset cmdReady", {31'd0, cmdReady}, 32'd1);
        checkOutput("midreset rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("midreset icc", {28'd0, icc}, 32'd0);
        checkOutput("midreset aluSel", {28'd0, aluSel}, {28'd0, OP_NOP});
        @(posedge clock);
        #1;
        applyStimulus(OP_ADD, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 4'b0000, 2);
        waitDrain();
        repeat (3) @(posedge clock);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
